sdc_alu_ctrl: RTL and testbench

Command sequencer that drives the sdc_alu from the issue side in the SDC DSP core. It accepts ALU commands over a valid/ready handshake and reads operands from a local register file. It presents operands and the function code to the external ALU, captures the result and carry, writes back, and maintains a status flag register.

---
 rtl/sdc_pkg.sv | 31 +++
 rtl/sdc_alu_ctrl_if.sv | 27 ++
 rtl/sdc_regfile.sv | 35 +++
 rtl/sdc_alu_ctrl.sv | 141 ++++++++++++++
 tb/tb_sdc_alu_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sdc_pkg.sv
// Shared types for the SDC ALU command sequencer: function codes, FSM states
// and the legality decoder used by the controller.
package sdc_pkg;

  localparam int FCN_W = 5;

  typedef enum logic [FCN_W-1:0] {
    FCN_NOT = 5'b00000,
    FCN_OR  = 5'b00001,
    FCN_AND = 5'b00010,
    FCN_XOR = 5'b00011,
    FCN_ADD = 5'b00100,
    FCN_SUB = 5'b00101,
    FCN_LDI = 5'b11111
  } alu_fcn_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } ctrl_state_e;

  function automatic logic is_legal(input logic [FCN_W-1:0] fcn);
    case (alu_fcn_e'(fcn))
      FCN_NOT, FCN_OR, FCN_AND, FCN_XOR,
      FCN_ADD, FCN_SUB, FCN_LDI: is_legal = 1'b1;
      default:                   is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sdc_alu_ctrl_if.sv
// Command issue bus of the SDC ALU sequencer (valid/ready handshake).
interface sdc_alu_ctrl_if
  import sdc_pkg::*;
#(
  parameter int BIT_WIDTH = 32,
  parameter int NREGS     = 8
);
  localparam int AW = $clog2(NREGS);

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [FCN_W-1:0]     cmd_fcn;
  logic [AW-1:0]        cmd_rd;
  logic [AW-1:0]        cmd_rs1;
  logic [AW-1:0]        cmd_rs2;
  logic [BIT_WIDTH-1:0] cmd_imm;

  modport master (
    output cmd_valid, cmd_fcn, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_fcn, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
    output cmd_ready
  );
endinterface

// File: rtl/sdc_regfile.sv
// Register file for the SDC ALU sequencer: two operand read ports, one debug
// read port, one synchronous write port; R0 always reads as zero.
module sdc_regfile #(
  parameter  int BIT_WIDTH = 32,
  parameter  int NREGS     = 8,
  localparam int AW        = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic [BIT_WIDTH-1:0] wdata,
  input  logic [AW-1:0]        raddr1,
  output logic [BIT_WIDTH-1:0] rdata1,
  input  logic [AW-1:0]        raddr2,
  output logic [BIT_WIDTH-1:0] rdata2,
  input  logic [AW-1:0]        dbg_addr,
  output logic [BIT_WIDTH-1:0] dbg_data
);

  logic [BIT_WIDTH-1:0] mem_q [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
    end else if (we && (waddr != '0)) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata1   = (raddr1   == '0) ? '0 : mem_q[raddr1];
  assign rdata2   = (raddr2   == '0) ? '0 : mem_q[raddr2];
  assign dbg_data = (dbg_addr == '0) ? '0 : mem_q[dbg_addr];

endmodule

// File: rtl/sdc_alu_ctrl.sv
// Three-cycle ALU command sequencer (IDLE -> EXEC -> WB) with status flags.
// Define SDC_ALU_CTRL_PERF_EN to build the perf_ops/perf_ill counters.
module sdc_alu_ctrl
  import sdc_pkg::*;
#(
  parameter  int BIT_WIDTH = 32,
  parameter  int NREGS     = 8,
  localparam int AW        = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  sdc_alu_ctrl_if.slave        cmd,
  output logic                 done,
  output logic [BIT_WIDTH-1:0] alu_in1,
  output logic [BIT_WIDTH-1:0] alu_in2,
  output logic [FCN_W-1:0]     alu_fcn,
  input  logic [BIT_WIDTH-1:0] alu_out,
  input  logic                 alu_cr,
  output logic                 st_c,
  output logic                 st_z,
  output logic                 st_n,
  output logic                 st_err,
  input  logic                 st_clr,
  input  logic [AW-1:0]        dbg_addr,
  output logic [BIT_WIDTH-1:0] dbg_data,
  output logic [15:0]          perf_ops,
  output logic [15:0]          perf_ill
);

  ctrl_state_e          state_q, state_d;
  logic [FCN_W-1:0]     fcn_q;
  logic [AW-1:0]        rd_q;
  logic [BIT_WIDTH-1:0] imm_q, res_q;
  logic                 c_q;
  logic [BIT_WIDTH-1:0] alu_in1_q, alu_in2_q;
  logic [FCN_W-1:0]     alu_fcn_q;
  logic                 st_c_q, st_z_q, st_n_q, st_err_q;
  logic [BIT_WIDTH-1:0] rdata1, rdata2;
  logic                 accept, wb_legal, wb_illegal;

  assign cmd.cmd_ready = (state_q == S_IDLE);
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;
  assign wb_legal      = (state_q == S_WB) &&  is_legal(fcn_q);
  assign wb_illegal    = (state_q == S_WB) && !is_legal(fcn_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_EXEC;
      S_EXEC:  state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      fcn_q     <= '0;
      rd_q      <= '0;
      imm_q     <= '0;
      res_q     <= '0;
      c_q       <= 1'b0;
      alu_in1_q <= '0;
      alu_in2_q <= '0;
      alu_fcn_q <= '0;
      st_c_q    <= 1'b0;
      st_z_q    <= 1'b0;
      st_n_q    <= 1'b0;
      st_err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      // IDLE: operands are read here, before any pending writeback could land
      if (accept) begin
        fcn_q     <= cmd.cmd_fcn;
        rd_q      <= cmd.cmd_rd;
        imm_q     <= cmd.cmd_imm;
        alu_in1_q <= rdata1;
        alu_in2_q <= rdata2;
        alu_fcn_q <= cmd.cmd_fcn;
      end
      // EXEC: sample the combinational ALU result
      if (state_q == S_EXEC) begin
        res_q <= (fcn_q == FCN_LDI) ? imm_q : alu_out;
        c_q   <= (fcn_q == FCN_ADD || fcn_q == FCN_SUB) ? alu_cr : 1'b0;
      end
      // WB: flags follow legal ops; an illegal WB beats a concurrent clear
      if (wb_legal) begin
        st_c_q <= c_q;
        st_z_q <= (res_q == '0);
        st_n_q <= res_q[BIT_WIDTH-1];
      end
      if (wb_illegal)  st_err_q <= 1'b1;
      else if (st_clr) st_err_q <= 1'b0;
    end
  end

  sdc_regfile #(.BIT_WIDTH(BIT_WIDTH), .NREGS(NREGS)) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we       (wb_legal),
    .waddr    (rd_q),
    .wdata    (res_q),
    .raddr1   (cmd.cmd_rs1),
    .rdata1   (rdata1),
    .raddr2   (cmd.cmd_rs2),
    .rdata2   (rdata2),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  assign done    = (state_q == S_WB);
  assign alu_in1 = alu_in1_q;
  assign alu_in2 = alu_in2_q;
  assign alu_fcn = alu_fcn_q;
  assign st_c    = st_c_q;
  assign st_z    = st_z_q;
  assign st_n    = st_n_q;
  assign st_err  = st_err_q;

`ifdef SDC_ALU_CTRL_PERF_EN
  logic [15:0] perf_ops_q, perf_ill_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_ops_q <= '0;
      perf_ill_q <= '0;
    end else begin
      if (wb_legal)   perf_ops_q <= perf_ops_q + 16'd1;
      if (wb_illegal) perf_ill_q <= perf_ill_q + 16'd1;
    end
  end

  assign perf_ops = perf_ops_q;
  assign perf_ill = perf_ill_q;
`else
  assign perf_ops = '0;
  assign perf_ill = '0;
`endif

endmodule

// File: tb/tb_sdc_alu_ctrl.sv
// Self-checking bench for sdc_alu_ctrl with an attached behavioural ALU.
module tb_sdc_alu_ctrl;
  import sdc_pkg::*;

  localparam int BW = 32;
  localparam int NR = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          done, alu_cr, st_c, st_z, st_n, st_err, st_clr;
  logic [BW-1:0] alu_in1, alu_in2, alu_out, dbg_data;
  logic [4:0]    alu_fcn;
  logic [AW-1:0] dbg_addr;
  logic [15:0]   perf_ops, perf_ill;

  always #5 clk = ~clk;

  sdc_alu_ctrl_if #(.BIT_WIDTH(BW), .NREGS(NR)) cif ();

  sdc_alu_ctrl #(.BIT_WIDTH(BW), .NREGS(NR)) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd      (cif),
    .done     (done),
    .alu_in1  (alu_in1),
    .alu_in2  (alu_in2),
    .alu_fcn  (alu_fcn),
    .alu_out  (alu_out),
    .alu_cr   (alu_cr),
    .st_c     (st_c),
    .st_z     (st_z),
    .st_n     (st_n),
    .st_err   (st_err),
    .st_clr   (st_clr),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .perf_ops (perf_ops),
    .perf_ill (perf_ill)
  );

  // Attached ALU; unknown codes (including LDI) return a junk value on purpose
  always_comb begin
    logic [BW:0] wide;
    wide    = '0;
    alu_out = 32'h1234_5678;
    alu_cr  = 1'b0;
    case (alu_fcn)
      5'b00000: alu_out = ~alu_in1;
      5'b00001: alu_out = alu_in1 | alu_in2;
      5'b00010: alu_out = alu_in1 & alu_in2;
      5'b00011: alu_out = alu_in1 ^ alu_in2;
      5'b00100: begin
        wide    = {1'b0, alu_in1} + {1'b0, alu_in2};
        alu_out = wide[BW-1:0];
        alu_cr  = wide[BW];
      end
      5'b00101: begin
        alu_out = alu_in1 - alu_in2;
        alu_cr  = (alu_in1 < alu_in2);
      end
      default: ;
    endcase
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: architectural state after each completed command
  logic [31:0] m_reg [NR];
  logic        m_c, m_z, m_n, m_err;
  int          m_ops, m_ill;

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_reg[i] = '0;
    m_c = 0; m_z = 0; m_n = 0; m_err = 0; m_ops = 0; m_ill = 0;
  endtask

  task automatic model_exec(input logic [4:0] fcn, input int rd, input int rs1,
                            input int rs2, input logic [31:0] imm, input bit clr);
    logic [31:0] a, b, r;
    logic        c;
    bit          legal;
    a = m_reg[rs1]; b = m_reg[rs2]; r = '0; c = 0; legal = 1;
    case (fcn)
      5'd0:  r = ~a;
      5'd1:  r = a | b;
      5'd2:  r = a & b;
      5'd3:  r = a ^ b;
      5'd4:  begin r = a + b; c = ({1'b0, a} + {1'b0, b}) > 33'hFFFF_FFFF; end
      5'd5:  begin r = a - b; c = (b > a); end
      5'd31: r = imm;
      default: legal = 0;
    endcase
    if (legal) begin
      if (rd != 0) m_reg[rd] = r;
      m_c = c; m_z = (r == 0); m_n = r[31];
      m_ops++;
      if (clr) m_err = 0;
    end else begin
      m_err = 1;
      m_ill++;
    end
  endtask

  task automatic check_perf();
`ifdef SDC_ALU_CTRL_PERF_EN
    chk("perf_ops", {16'd0, perf_ops}, {16'd0, m_ops[15:0]});
    chk("perf_ill", {16'd0, perf_ill}, {16'd0, m_ill[15:0]});
`else
    chk("perf_ops_tied", {16'd0, perf_ops}, 32'd0);
    chk("perf_ill_tied", {16'd0, perf_ill}, 32'd0);
`endif
  endtask

  task automatic check_state(input int rd);
    dbg_addr = AW'(rd);
    #1;
    chk($sformatf("reg_r%0d", rd), dbg_data, m_reg[rd]);
    chk("st_c", st_c, m_c);
    chk("st_z", st_z, m_z);
    chk("st_n", st_n, m_n);
    chk("st_err", st_err, m_err);
  endtask

  // Issue one command and check the handshake timing around it
  task automatic send(input logic [4:0] fcn, input int rd, input int rs1, input int rs2,
                      input logic [31:0] imm, input bit clr);
    logic [31:0] exp_in1, exp_in2;
    int          wait_cyc;
    @(negedge clk);
    cif.cmd_valid = 1'b1;
    cif.cmd_fcn   = fcn;
    cif.cmd_rd    = AW'(rd);
    cif.cmd_rs1   = AW'(rs1);
    cif.cmd_rs2   = AW'(rs2);
    cif.cmd_imm   = imm;
    st_clr        = clr;
    wait_cyc      = 0;
    while (!cif.cmd_ready && wait_cyc < 20) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (!cif.cmd_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got ready=0 expected ready=1 within 20 cycles");
    end
    exp_in1 = m_reg[rs1];
    exp_in2 = m_reg[rs2];
    @(posedge clk);
    model_exec(fcn, rd, rs1, rs2, imm, clr);
    @(negedge clk);
    cif.cmd_valid = 1'b0;
    chk("done_in_exec", done, 1'b0);
    chk("ready_in_exec", cif.cmd_ready, 1'b0);
    @(negedge clk);
    chk("done_in_wb", done, 1'b1);
    @(negedge clk);
    chk("done_after_wb", done, 1'b0);
    chk("ready_after_wb", cif.cmd_ready, 1'b1);
    st_clr = 1'b0;
    chk("alu_fcn_hold", alu_fcn, fcn);
    chk("alu_in1", alu_in1, exp_in1);
    chk("alu_in2", alu_in2, exp_in2);
  endtask

  typedef struct {
    logic [4:0]  fcn;
    int          rd, rs1, rs2;
    logic [31:0] imm;
    logic [31:0] exp_res;
    logic        exp_c, exp_z, exp_n, exp_err;
  } vec_t;

  vec_t vecs [14];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //           fcn      rd rs1 rs2 imm            exp_res        c  z  n  err
    vecs[0]  = '{5'd31,   1, 0, 0, 32'd5,          32'd5,          0, 0, 0, 0};
    vecs[1]  = '{5'd31,   2, 0, 0, 32'd3,          32'd3,          0, 0, 0, 0};
    vecs[2]  = '{5'd5,    3, 1, 2, 32'd0,          32'd2,          0, 0, 0, 0};
    vecs[3]  = '{5'd5,    4, 2, 1, 32'd0,          32'hFFFF_FFFE,  1, 0, 1, 0};
    vecs[4]  = '{5'd31,   5, 0, 0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  0, 0, 1, 0};
    vecs[5]  = '{5'd31,   6, 0, 0, 32'd1,          32'd1,          0, 0, 0, 0};
    vecs[6]  = '{5'd4,    7, 5, 6, 32'd0,          32'd0,          1, 1, 0, 0};
    vecs[7]  = '{5'd3,    7, 1, 1, 32'd0,          32'd0,          0, 1, 0, 0};
    vecs[8]  = '{5'b01000,1, 2, 3, 32'd77,         32'd5,          0, 1, 0, 1};
    vecs[9]  = '{5'd31,   0, 0, 0, 32'hDEAD_BEEF,  32'd0,          0, 0, 1, 1};
    vecs[10] = '{5'd1,    2, 1, 6, 32'd0,          32'd5,          0, 0, 0, 1};
    vecs[11] = '{5'd2,    3, 4, 5, 32'd0,          32'hFFFF_FFFE,  0, 0, 1, 1};
    vecs[12] = '{5'd0,    4, 1, 0, 32'd0,          32'hFFFF_FFFA,  0, 0, 1, 1};
    vecs[13] = '{5'd4,    1, 1, 1, 32'd0,          32'd10,         0, 0, 0, 1};

    rst = 1'b1; st_clr = 1'b0; dbg_addr = '0;
    cif.cmd_valid = 1'b0; cif.cmd_fcn = '0; cif.cmd_rd = '0;
    cif.cmd_rs1 = '0; cif.cmd_rs2 = '0; cif.cmd_imm = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_ready", cif.cmd_ready, 1'b1);
    chk("rst_done", done, 1'b0);
    chk("rst_alu_in1", alu_in1, 32'd0);
    chk("rst_alu_in2", alu_in2, 32'd0);
    chk("rst_alu_fcn", alu_fcn, 32'd0);
    check_perf();
    for (int i = 0; i < NR; i++) check_state(i);

    // Directed table
    for (int i = 0; i < 14; i++) begin
      send(vecs[i].fcn, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm, 1'b0);
      dbg_addr = AW'(vecs[i].rd);
      #1;
      chk($sformatf("vec%0d_res", i), dbg_data, vecs[i].exp_res);
      chk($sformatf("vec%0d_c", i), st_c, vecs[i].exp_c);
      chk($sformatf("vec%0d_z", i), st_z, vecs[i].exp_z);
      chk($sformatf("vec%0d_n", i), st_n, vecs[i].exp_n);
      chk($sformatf("vec%0d_err", i), st_err, vecs[i].exp_err);
    end
    check_perf();

    // Clearing the sticky error, then a clear colliding with an illegal WB
    @(negedge clk); st_clr = 1'b1;
    @(negedge clk); st_clr = 1'b0;
    m_err = 0;
    chk("err_cleared", st_err, 1'b0);
    send(5'b10000, 2, 1, 1, 32'd0, 1'b1);
    chk("err_set_wins", st_err, 1'b1);
    check_state(2);
    @(negedge clk); st_clr = 1'b1;
    @(negedge clk); st_clr = 1'b0;
    m_err = 0;
    chk("err_cleared2", st_err, 1'b0);

    // Back-to-back issue with cmd_valid held high
    begin
      int  acc, last;
      bit  gap_ok;
      acc = 0; last = -1; gap_ok = 1;
      @(negedge clk);
      cif.cmd_valid = 1'b1; cif.cmd_fcn = 5'd31; cif.cmd_rd = '0;
      cif.cmd_rs1 = 3'd1; cif.cmd_rs2 = 3'd2; cif.cmd_imm = 32'h8000_0001;
      for (int cyc = 0; cyc < 12; cyc++) begin
        if (cif.cmd_ready) begin
          if (last >= 0 && cyc - last != 3) gap_ok = 0;
          last = cyc;
          acc++;
          model_exec(5'd31, 0, 1, 2, 32'h8000_0001, 1'b0);
        end
        @(negedge clk);
      end
      cif.cmd_valid = 1'b0;
      chk("b2b_accepts", acc, 4);
      chk("b2b_spacing", gap_ok, 1'b1);
      check_state(0);
      check_perf();
    end

    // Reset during EXEC aborts the ADD
    send(5'd31, 1, 0, 0, 32'd7, 1'b0);
    send(5'd31, 2, 0, 0, 32'd9, 1'b0);
    @(negedge clk);
    cif.cmd_valid = 1'b1; cif.cmd_fcn = 5'd4; cif.cmd_rd = 3'd3;
    cif.cmd_rs1 = 3'd1; cif.cmd_rs2 = 3'd2; cif.cmd_imm = '0;
    @(posedge clk);
    @(negedge clk);
    cif.cmd_valid = 1'b0;
    chk("abort_in_exec", done, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk("abort_ready", cif.cmd_ready, 1'b1);
    chk("abort_alu_in1", alu_in1, 32'd0);
    for (int k = 0; k < 4; k++) begin
      chk("abort_no_done", done, 1'b0);
      @(negedge clk);
    end
    check_state(3);
    check_state(1);
    check_perf();

    // Randomised commands against the model
    for (int n = 0; n < 60; n++) begin
      logic [4:0]  fcn;
      logic [31:0] imm;
      int          sel, rd, rs1, rs2;
      sel = $urandom_range(0, 9);
      if (sel < 6)      fcn = 5'(sel);
      else if (sel < 8) fcn = 5'd31;
      else              fcn = 5'($urandom_range(6, 30));
      rd  = $urandom_range(0, NR - 1);
      rs1 = $urandom_range(0, NR - 1);
      rs2 = $urandom_range(0, NR - 1);
      imm = $urandom;
      if ($urandom_range(0, 5) == 0) imm = 32'd0;
      send(fcn, rd, rs1, rs2, imm, 1'b0);
      check_state(rd);
    end
    for (int i = 0; i < NR; i++) check_state(i);
    check_perf();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
